// File: rtl/mem_arb_ctrl.sv
// Arbitrates N_REQ producers into the single MEM write port and drains MEM to a consumer.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module mem_arb_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned N_REQ  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*(DATA_W+2)-1:0]   req_data,
    output logic [N_REQ-1:0]              req_ready,
    input  logic                          train_done,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W+1:0]             out_data,
    output logic                          drain_done,
    output logic [ADDR_W:0]               count,
    output logic                          full,
    output logic                          empty,
    output logic                          mem_rst,
    output logic                          mem_wr_en,
    output logic                          mem_rd_en,
    output logic [DATA_W+1:0]             mem_data_in,
    input  logic [DATA_W+1:0]             mem_data_out
);

    localparam int unsigned WORD_W = DATA_W + 2;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [0:0] {StFill, StDrain} state_e;

    state_e             state_q;
    logic [ADDR_W:0]    count_q;
    logic               out_valid_q;
    logic               drain_done_q;

    logic [IDX_W-1:0]   rr_start;
    logic [IDX_W-1:0]   gidx;
    logic [IDX_W:0]     scan_idx;
    logic               found;
    logic [N_REQ-1:0]   grant;
    logic               wr;
    logic               rd;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign rr_start = '0;
`else
    logic [IDX_W-1:0]   rr_q;
    assign rr_start = rr_q;
`endif

    // Scan requesters starting at rr_start, wrapping modulo N_REQ.
    always_comb begin
        found    = 1'b0;
        gidx     = '0;
        scan_idx = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            scan_idx = {1'b0, rr_start} + (IDX_W+1)'(off);
            if (scan_idx >= (IDX_W+1)'(N_REQ)) begin
                scan_idx = scan_idx - (IDX_W+1)'(N_REQ);
            end
            if (!found && req_valid[scan_idx[IDX_W-1:0]]) begin
                found = 1'b1;
                gidx  = scan_idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        grant       = '0;
        mem_data_in = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant[i] = found && (gidx == IDX_W'(i));
            if (grant[i]) begin
                mem_data_in = req_data[i*WORD_W +: WORD_W];
            end
        end
    end

    assign full  = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty = (count_q == '0);

    // Strobes are suppressed while rst is low; MEM is being cleared anyway.
    assign wr = rst && found && !full;
    assign rd = rst && (state_q == StDrain) && !empty && (!out_valid_q || out_ready);

    assign req_ready  = wr ? grant : '0;
    assign mem_wr_en  = wr;
    assign mem_rd_en  = rd;
    assign mem_rst    = ~rst;
    assign out_data   = mem_data_out;
    assign out_valid  = out_valid_q;
    assign drain_done = drain_done_q;
    assign count      = count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StFill;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            drain_done_q <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_q         <= '0;
`endif
        end else begin
            drain_done_q <= 1'b0;
            case (state_q)
                StFill: begin
                    if (train_done) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (empty && !out_valid_q && !wr) begin
                        state_q      <= StFill;
                        drain_done_q <= 1'b1;
                    end
                end
                default: state_q <= StFill;
            endcase

            if (wr && !rd) begin
                count_q <= count_q + (ADDR_W+1)'(1);
            end else if (rd && !wr) begin
                count_q <= count_q - (ADDR_W+1)'(1);
            end

            if (rd) begin
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

`ifndef MEM_ARB_FIXED_PRIO_EN
            if (wr) begin
                rr_q <= (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + IDX_W'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Bench for mem_arb_ctrl: directed scenarios then random traffic, checked each cycle
// against a queue-based model of the arbiter, MEM occupancy and drain handshake.
module tb_mem_arb_ctrl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned N_REQ  = 2;
    localparam int unsigned W      = DATA_W + 2;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*W-1:0]    req_data;
    logic [N_REQ-1:0]      req_ready;
    logic                  train_done;
    logic                  out_valid;
    logic                  out_ready;
    logic [W-1:0]          out_data;
    logic                  drain_done;
    logic [ADDR_W:0]       count;
    logic                  full;
    logic                  empty;
    logic                  mem_rst;
    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic [W-1:0]          mem_data_in;
    logic [W-1:0]          mem_data_out;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arb_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .N_REQ  (N_REQ)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .train_done   (train_done),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .drain_done   (drain_done),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .mem_rst      (mem_rst),
        .mem_wr_en    (mem_wr_en),
        .mem_rd_en    (mem_rd_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural MEM: a plain FIFO driven by the DUT strobes.
    logic [W-1:0] mem_arr [DEPTH];
    int unsigned  mem_wp = 0;
    int unsigned  mem_rp = 0;
    always @(posedge clk) begin
        if (mem_rst) begin
            mem_wp <= 0;
            mem_rp <= 0;
        end else begin
            if (mem_wr_en) begin
                mem_arr[mem_wp] <= mem_data_in;
                mem_wp          <= (mem_wp + 1) % DEPTH;
            end
            if (mem_rd_en) begin
                mem_data_out <= mem_arr[mem_rp];
                mem_rp       <= (mem_rp + 1) % DEPTH;
            end
        end
    end

    // Reference model state.
    logic [W-1:0] m_q [$];
    logic [W-1:0] m_word;
    bit           m_ov    = 1'b0;
    bit           m_drain = 1'b0;
    bit           m_dd    = 1'b0;
    int           m_rr    = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Called at a falling edge with inputs already driven; checks, then advances one cycle.
    task automatic tick();
        int           g;
        int           start;
        bit           m_full;
        bit           m_empty;
        bit           e_wr;
        bit           e_rd;
        logic [N_REQ-1:0] e_ready;
        logic [W-1:0] e_word;
        #1;
        m_full  = (m_q.size() == DEPTH);
        m_empty = (m_q.size() == 0);
`ifdef MEM_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = m_rr;
`endif
        g = -1;
        for (int off = 0; off < N_REQ; off++) begin
            if (g < 0 && req_valid[(start + off) % N_REQ]) g = (start + off) % N_REQ;
        end
        e_wr    = rst && !m_full && (g >= 0);
        e_ready = '0;
        e_word  = '0;
        if (e_wr) begin
            e_ready[g] = 1'b1;
            e_word     = req_data[g*W +: W];
        end
        e_rd = rst && m_drain && !m_empty && (!m_ov || out_ready);

        check_eq("mem_rst",    mem_rst,    !rst);
        check_eq("req_ready",  req_ready,  e_ready);
        check_eq("mem_wr_en",  mem_wr_en,  e_wr);
        check_eq("mem_rd_en",  mem_rd_en,  e_rd);
        check_eq("count",      count,      m_q.size());
        check_eq("full",       full,       m_full);
        check_eq("empty",      empty,      m_empty);
        check_eq("out_valid",  out_valid,  m_ov);
        check_eq("drain_done", drain_done, m_dd);
        if (m_ov) check_eq("out_data", out_data, m_word);
        if (e_wr) check_eq("mem_data_in", mem_data_in, e_word);

        @(posedge clk);
        if (!rst) begin
            m_q.delete();
            m_ov    = 1'b0;
            m_drain = 1'b0;
            m_dd    = 1'b0;
            m_rr    = 0;
        end else begin
            m_dd = 1'b0;
            if (!m_drain && train_done) begin
                m_drain = 1'b1;
            end else if (m_drain && m_empty && !m_ov && !e_wr) begin
                m_drain = 1'b0;
                m_dd    = 1'b1;
            end
            if (e_rd) m_word = m_q.pop_front();
            if (e_wr) begin
                m_q.push_back(e_word);
                m_rr = (g + 1) % N_REQ;
            end
            if (e_rd) m_ov = 1'b1;
            else if (m_ov && out_ready) m_ov = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_word(input int i, input logic [W-1:0] w);
        req_data[i*W +: W] = w;
    endtask

    task automatic pulse_train();
        train_done = 1'b1;
        tick();
        train_done = 1'b0;
    endtask

    task automatic fill(input int n);
        for (int k = 0; k < n; k++) begin
            set_word(0, {2'($urandom), 32'($urandom)});
            req_valid = 'b1;
            tick();
        end
        req_valid = '0;
    endtask

    bit bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] drain_words [3];

    initial begin
        rst        = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        train_done = 1'b0;
        out_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        run(2);
        rst = 1'b1;

        // Round-robin: both requesters valid until full, one extra cycle refused.
        set_word(0, 34'h13DCCCCCD);
        set_word(1, 34'h13F800000);
        req_valid = 2'b11;
        run(5);
        req_valid = '0;
        out_ready = 1'b1;
        pulse_train();
        run(8);

        // In-order drain of three known words.
        drain_words[0] = 34'h13F800000;
        drain_words[1] = 34'h13F800001;
        drain_words[2] = 34'h13F800003;
        for (int k = 0; k < 3; k++) begin
            set_word(1, drain_words[k]);
            req_valid = 2'b10;
            tick();
        end
        req_valid = '0;
        pulse_train();
        run(6);

        // Backpressure.
        fill(4);
        pulse_train();
        for (int k = 0; k < 16; k++) begin
            out_ready = bp_pat[k % 4];
            tick();
        end
        out_ready = 1'b1;
        run(4);

        // Simultaneous read and write while draining.
        fill(2);
        pulse_train();
        for (int k = 0; k < 6; k++) begin
            set_word(0, {2'($urandom), 32'($urandom)});
            req_valid = 'b1;
            tick();
        end
        req_valid = '0;
        run(6);

        // Reset in the middle of a drain.
        fill(3);
        out_ready = 1'b0;
        pulse_train();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        run(3);

        // Random traffic, occasional reset.
        for (int k = 0; k < 3000; k++) begin
            req_valid  = N_REQ'($urandom);
            for (int i = 0; i < N_REQ; i++) set_word(i, {2'($urandom), 32'($urandom)});
            train_done = ($urandom_range(0, 15) == 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
